// File: rtl/switch_allocator_pkg.sv
// Shared allocator/NoC definitions: flit IDs, default sizes, FSM encodings
// and an index-width helper used for select and pointer fields.
package switch_allocator_pkg;

  localparam int unsigned NOC_DATA_W = 32;
  localparam int unsigned NOC_IN_N   = 5;
  localparam int unsigned NOC_OUT_M  = 5;

  typedef enum logic [1:0] {
    FLIT_HEAD      = 2'b00,
    FLIT_BODY      = 2'b01,
    FLIT_TAIL      = 2'b10,
    FLIT_HEAD_TAIL = 2'b11
  } flit_id_e;

  typedef enum logic {
    ALLOC_IDLE   = 1'b0,
    ALLOC_LOCKED = 1'b1
  } alloc_state_e;

  // Index width that never collapses to zero bits for a single-entry range.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr_i, scanning upward with wrap. Pointer storage lives in the caller.
//   req_i     : request vector
//   ptr_i     : highest-priority index for this cycle
//   gnt_o     : one-hot grant
//   gnt_idx_o : index of the granted requester
//   any_o     : at least one request present
module rr_arbiter
  import switch_allocator_pkg::*;
#(
  parameter  int unsigned N     = 5,
  localparam int unsigned PTR_W = idx_w(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [PTR_W-1:0] gnt_idx_o,
  output logic             any_o
);

  int unsigned     start_idx;
  int unsigned     sum;
  logic [PTR_W-1:0] idx;

  // Rotating priority scan; an out-of-range pointer behaves as 0.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    start_idx = (32'(ptr_i) < N) ? 32'(ptr_i) : 32'd0;
    sum       = 0;
    idx       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      sum = start_idx + k;
      if (sum >= N) sum = sum - N;
      idx = PTR_W'(sum);
      if (!any_o && req_i[idx]) begin
        any_o      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Packet-level switch allocator for an IN_N x OUT_M crossbar. Each output runs
// a round-robin arbiter and stays locked to the winning input from head to tail.
// Optional per-output stall watchdog: define SWITCH_ALLOC_WDOG_EN.
//   clk_i, rst_ni : clock, async active-low reset
//   in_valid_i    : input i has a flit at its buffer head
//   in_tail_i     : that flit ends its packet
//   in_dst_i      : destination output per input, DST_W bits each
//   in_ready_o    : flit of input i consumed this cycle
//   out_ready_i   : output channel j accepts a flit
//   out_valid_o   : output channel j carries a valid flit
//   sel_o         : crossbar select, field j = owning input of output j
//   wdog_err_o    : one-cycle stall-timeout pulse (watchdog build only)
module switch_allocator
  import switch_allocator_pkg::*;
#(
  parameter int unsigned IN_N        = NOC_IN_N,
  parameter int unsigned OUT_M       = NOC_OUT_M,
  parameter int unsigned DST_W       = idx_w(OUT_M),
  parameter int unsigned SEL_W       = idx_w(IN_N),
  parameter int unsigned WDOG_CYCLES = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [IN_N-1:0]         in_valid_i,
  input  logic [IN_N-1:0]         in_tail_i,
  input  logic [IN_N*DST_W-1:0]   in_dst_i,
  output logic [IN_N-1:0]         in_ready_o,
  input  logic [OUT_M-1:0]        out_ready_i,
  output logic [OUT_M-1:0]        out_valid_o,
  output logic [OUT_M*SEL_W-1:0]  sel_o
`ifdef SWITCH_ALLOC_WDOG_EN
  ,
  output logic [OUT_M-1:0]        wdog_err_o
`endif
);

  // Elaboration-time parameter sanity.
  if (SEL_W != idx_w(IN_N)) begin : g_bad_sel_w
    $error("SEL_W must equal the arbiter index width");
  end
  if (WDOG_CYCLES < 1) begin : g_bad_wdog
    $error("WDOG_CYCLES must be at least 1");
  end

  alloc_state_e state_q [OUT_M];
  alloc_state_e state_d [OUT_M];

  logic [OUT_M-1:0][SEL_W-1:0] owner_q, owner_d;
  logic [OUT_M-1:0][SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [OUT_M-1:0][SEL_W-1:0] gnt_idx;
  logic [OUT_M-1:0][IN_N-1:0]  req;
  logic [OUT_M-1:0][IN_N-1:0]  gnt_unused;  // one-hot form not needed; index drives owner
  logic [OUT_M-1:0]            gnt_any;
  logic [OUT_M-1:0]            xfer;
  logic [IN_N-1:0]             owns;

`ifdef SWITCH_ALLOC_WDOG_EN
  localparam int unsigned CNT_W = $clog2(WDOG_CYCLES + 1);
  logic [OUT_M-1:0][CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [OUT_M-1:0]            wdog_hit;
`endif

  // Requests: an input that already owns an output asks for nothing, and an
  // out-of-range destination matches no output.
  always_comb begin
    owns = '0;
    req  = '0;
    for (int unsigned j = 0; j < OUT_M; j++) begin
      if (state_q[j] == ALLOC_LOCKED) owns[owner_q[j]] = 1'b1;
    end
    for (int unsigned j = 0; j < OUT_M; j++) begin
      for (int unsigned i = 0; i < IN_N; i++) begin
        req[j][i] = in_valid_i[i] && !owns[i] &&
                    (in_dst_i[i*DST_W +: DST_W] == DST_W'(j));
      end
    end
  end

  for (genvar j = 0; j < OUT_M; j++) begin : g_arb
    rr_arbiter #(.N(IN_N)) u_arb (
      .req_i     (req[j]),
      .ptr_i     (rr_ptr_q[j]),
      .gnt_o     (gnt_unused[j]),
      .gnt_idx_o (gnt_idx[j]),
      .any_o     (gnt_any[j])
    );
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned j = 0; j < OUT_M; j++) state_q[j] <= ALLOC_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
`ifdef SWITCH_ALLOC_WDOG_EN
      stall_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
`ifdef SWITCH_ALLOC_WDOG_EN
      stall_cnt_q <= stall_cnt_d;
`endif
    end
  end

  // Next-state: grant from IDLE, release on tail transfer (or watchdog).
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
`ifdef SWITCH_ALLOC_WDOG_EN
    stall_cnt_d = '0;
`endif
    for (int unsigned j = 0; j < OUT_M; j++) begin
      case (state_q[j])
        ALLOC_IDLE: begin
          if (gnt_any[j]) begin
            state_d[j]  = ALLOC_LOCKED;
            owner_d[j]  = gnt_idx[j];
            rr_ptr_d[j] = (gnt_idx[j] == SEL_W'(IN_N - 1)) ? '0 : gnt_idx[j] + SEL_W'(1);
          end
        end
        ALLOC_LOCKED: begin
          if (xfer[j] && in_tail_i[owner_q[j]]) state_d[j] = ALLOC_IDLE;
`ifdef SWITCH_ALLOC_WDOG_EN
          if (wdog_hit[j]) state_d[j] = ALLOC_IDLE;
          if (!xfer[j] && !wdog_hit[j]) stall_cnt_d[j] = stall_cnt_q[j] + CNT_W'(1);
`endif
        end
        default: state_d[j] = ALLOC_IDLE;
      endcase
    end
  end

  // Outputs: handshake follows the owner directly while locked.
  always_comb begin
    out_valid_o = '0;
    in_ready_o  = '0;
    xfer        = '0;
`ifdef SWITCH_ALLOC_WDOG_EN
    wdog_hit    = '0;
`endif
    for (int unsigned j = 0; j < OUT_M; j++) begin
      if (state_q[j] == ALLOC_LOCKED) begin
        out_valid_o[j] = in_valid_i[owner_q[j]];
        xfer[j]        = out_valid_o[j] && out_ready_i[j];
        if (xfer[j]) in_ready_o[owner_q[j]] = 1'b1;
`ifdef SWITCH_ALLOC_WDOG_EN
        wdog_hit[j] = !xfer[j] && (stall_cnt_q[j] == CNT_W'(WDOG_CYCLES - 1));
`endif
      end
    end
  end

  // Select holds its last owner while idle; valid is low then.
  assign sel_o = owner_q;

`ifdef SWITCH_ALLOC_WDOG_EN
  assign wdog_err_o = wdog_hit;
`endif

endmodule
